// File: rtl/host_spi_slave_pkg.sv
// Shared types and frame field widths for the host SPI slave.
// Field widths, FSM state encoding and bit-counter sizing helper.
package host_spi_slave_pkg;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 8;

  typedef enum logic [2:0] {
    ST_WAIT_CS,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_OVERRUN
  } state_e;

  function automatic int cnt_width(input int data_bits);
    return $clog2(CMD_BITS + ADDR_BITS + data_bits) + 1;
  endfunction

endpackage

// File: rtl/host_spi_slave_if.sv
// Decoded-frame bus from the SPI slave to the slot drivers.
// master: driven by host_spi_slave; slave: consumed by slot drivers.
interface host_spi_slave_if
  import host_spi_slave_pkg::*;
#(
  parameter int DATA_BITS = 48
);

  logic [CMD_BITS-1:0]  spi_cmd_r;
  logic                 spi_cmd_valid_r;
  logic [ADDR_BITS-1:0] spi_addr_r;
  logic                 spi_addr_valid_r;
  logic [DATA_BITS-1:0] spi_data_r;
  logic                 spi_data_valid_r;
  logic                 spi_done;
  logic                 frame_error;

  modport master (
    output spi_cmd_r,
    output spi_cmd_valid_r,
    output spi_addr_r,
    output spi_addr_valid_r,
    output spi_data_r,
    output spi_data_valid_r,
    output spi_done,
    output frame_error
  );

  modport slave (
    input spi_cmd_r,
    input spi_cmd_valid_r,
    input spi_addr_r,
    input spi_addr_valid_r,
    input spi_data_r,
    input spi_data_valid_r,
    input spi_done,
    input frame_error
  );

endinterface

// File: rtl/host_spi_slave_sync_edge.sv
// Multi-flop synchroniser with rise/fall strobes for one async pin.
// Ports: clk, rst_n, d (async in), q (sync level), rise, fall.
module host_spi_slave_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset low: a chip select held low through reset never looks idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/host_spi_slave.sv
// SPI mode-0 slave: deserialises cmd/addr/data frames, returns rd_data.
// Ports: clk, resetn, host_* pins, rd_data, bus (decoded frame outputs).
module host_spi_slave
  import host_spi_slave_pkg::*;
#(
  parameter int DATA_BITS   = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 host_sck,
  input  logic                 host_cs_n,
  input  logic                 host_mosi,
  output logic                 host_miso,
  input  logic [DATA_BITS-1:0] rd_data,
  host_spi_slave_if.master     bus
);

  localparam int CNT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(CMD_BITS + ADDR_BITS);
  localparam logic [CNT_W-1:0] CNT_DATA =
    CNT_W'(CMD_BITS + ADDR_BITS + DATA_BITS);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl;

  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [CMD_BITS-1:0]  cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 cmd_v_q, cmd_v_d;
  logic                 addr_v_q, addr_v_d;
  logic                 data_v_q, data_v_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] miso_q, miso_d;
  logic [1:0]           ld_q, ld_d;

  host_spi_slave_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sck_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (host_sck),
    .q     (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  host_spi_slave_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (host_cs_n),
    .q     (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same depth as the sck chain, so mosi_lvl is the bit at sck_rise.
  always_comb begin
    mosi_d   = {mosi_q[SYNC_STAGES-2:0], host_mosi};
    mosi_lvl = mosi_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cmd_v_d  = cmd_v_q;
    addr_v_d = addr_v_q;
    data_v_d = data_v_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    miso_d   = miso_q;
    ld_d     = {ld_q[0], 1'b0};
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      ST_WAIT_CS: begin
        // Bus must look idle (cs high, mode-0 sck low) first.
        if (cs_lvl && !sck_lvl) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_CMD;
          cnt_d    = '0;
          cmd_v_d  = 1'b0;
          addr_v_d = 1'b0;
          data_v_d = 1'b0;
          miso_d   = '0;
        end
      end
      default: begin
        if (cs_rise) begin
          // cs_n edge wins over a coincident sck edge.
          state_d = ST_IDLE;
          done_d  = (cnt_q >= CNT_CMD);
          // Any count that is not whole bytes is malformed.
          err_d   = (cnt_q[2:0] != 3'd0);
        end else if (sck_rise) begin
          cnt_d = cnt_inc;
          rx_d  = {rx_q[DATA_BITS-2:0], mosi_lvl};
          if (state_q == ST_CMD && cnt_inc == CNT_CMD) begin
            cmd_d   = rx_d[CMD_BITS-1:0];
            cmd_v_d = 1'b1;
            state_d = ST_ADDR;
          end
          if (state_q == ST_ADDR && cnt_inc == CNT_ADDR) begin
            addr_d   = rx_d[ADDR_BITS-1:0];
            addr_v_d = 1'b1;
            ld_d[0]  = 1'b1;
            state_d  = ST_DATA;
          end
          if (state_q == ST_DATA && cnt_inc == CNT_DATA) begin
            data_d   = rx_d;
            data_v_d = 1'b1;
            state_d  = ST_OVERRUN;
          end
        end else if (sck_fall && state_q == ST_DATA
                     && cnt_q > CNT_ADDR) begin
          // The fall closing the last addr bit keeps the MSB on MISO.
          miso_d = {miso_q[DATA_BITS-2:0], 1'b0};
        end
      end
    endcase

    if (ld_q[1]) miso_d = rd_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mosi_q   <= '0;
      state_q  <= ST_WAIT_CS;
      cnt_q    <= '0;
      rx_q     <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cmd_v_q  <= 1'b0;
      addr_v_q <= 1'b0;
      data_v_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      miso_q   <= '0;
      ld_q     <= '0;
    end else begin
      mosi_q   <= mosi_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cmd_v_q  <= cmd_v_d;
      addr_v_q <= addr_v_d;
      data_v_q <= data_v_d;
      done_q   <= done_d;
      err_q    <= err_d;
      miso_q   <= miso_d;
      ld_q     <= ld_d;
    end
  end

  assign host_miso = (state_q == ST_DATA) & miso_q[DATA_BITS-1];

  assign bus.spi_cmd_r        = cmd_q;
  assign bus.spi_cmd_valid_r  = cmd_v_q;
  assign bus.spi_addr_r       = addr_q;
  assign bus.spi_addr_valid_r = addr_v_q;
  assign bus.spi_data_r       = data_q;
  assign bus.spi_data_valid_r = data_v_q;
  assign bus.spi_done         = done_q;
  assign bus.frame_error      = err_q;

endmodule

// File: tb/tb_host_spi_slave.sv
// Directed testbench for host_spi_slave (10 MHz SPI, 100 MHz clk).
// Counts done/error pulses and checks latched fields per scenario.
module tb_host_spi_slave;

  localparam int DB = 48;

  logic          clk;
  logic          resetn;
  logic          host_sck;
  logic          host_cs_n;
  logic          host_mosi;
  logic          host_miso;
  logic [DB-1:0] rd_data;

  host_spi_slave_if #(.DATA_BITS(DB)) bus ();

  host_spi_slave #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .host_sck  (host_sck),
    .host_cs_n (host_cs_n),
    .host_mosi (host_mosi),
    .host_miso (host_miso),
    .rd_data   (rd_data),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [127:0] miso_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.spi_done)    n_done <= n_done + 1;
    if (bus.frame_error) n_err  <= n_err + 1;
  end

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      host_mosi = v[n-1-i];
      #50;
      miso_cap[n-1-i] = host_miso;
      host_sck = 1'b1;
      #50;
      host_sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [127:0] v, input int n);
    host_cs_n = 1'b0;
    #50;
    send_bits(v, n);
    #50;
    host_cs_n = 1'b1;
    #100;
  endtask

  task automatic test_reset;
    #30;
    total++; if (bus.spi_cmd_r !== 8'h00) begin bad++;
      $display("FAIL rst_cmd got=%h exp=00", bus.spi_cmd_r); end
    total++; if (bus.spi_cmd_valid_r !== 1'b0) begin bad++;
      $display("FAIL rst_cmd_v got=%b exp=0", bus.spi_cmd_valid_r); end
    total++; if (bus.spi_data_valid_r !== 1'b0) begin bad++;
      $display("FAIL rst_data_v got=%b exp=0", bus.spi_data_valid_r); end
    total++; if (bus.spi_done !== 1'b0 || bus.frame_error !== 1'b0) begin
      bad++; $display("FAIL rst_pulse got=%b%b exp=00",
                      bus.spi_done, bus.frame_error); end
    total++; if (host_miso !== 1'b0) begin bad++;
      $display("FAIL rst_miso got=%b exp=0", host_miso); end
    resetn = 1'b1;
    #100;
  endtask

  task automatic test_full_frame;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    do_frame({8'hA5, 8'h03, 48'h123456789ABC}, 64);
    total++; if (bus.spi_cmd_r !== 8'hA5) begin bad++;
      $display("FAIL full_cmd got=%h exp=a5", bus.spi_cmd_r); end
    total++; if (bus.spi_addr_r !== 8'h03) begin bad++;
      $display("FAIL full_addr got=%h exp=03", bus.spi_addr_r); end
    total++; if (bus.spi_data_r !== 48'h123456789ABC) begin bad++;
      $display("FAIL full_data got=%h exp=123456789abc", bus.spi_data_r); end
    total++; if ({bus.spi_cmd_valid_r, bus.spi_addr_valid_r,
                  bus.spi_data_valid_r} !== 3'b111) begin bad++;
      $display("FAIL full_valids got=%b%b%b exp=111", bus.spi_cmd_valid_r,
               bus.spi_addr_valid_r, bus.spi_data_valid_r); end
    total++; if (n_done - d0 !== 1) begin bad++;
      $display("FAIL full_done got=%0d exp=1", n_done - d0); end
    total++; if (n_err - e0 !== 0) begin bad++;
      $display("FAIL full_err got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_readback;
    rd_data = 48'hFEDCBA987654;
    do_frame({8'h42, 8'h07, 48'h0}, 64);
    total++; if (miso_cap[47:0] !== 48'hFEDCBA987654) begin bad++;
      $display("FAIL rb_data got=%h exp=fedcba987654", miso_cap[47:0]); end
    total++; if (miso_cap[63:48] !== 16'h0000) begin bad++;
      $display("FAIL rb_hdr got=%h exp=0000", miso_cap[63:48]); end
  endtask

  task automatic test_cmd_only;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    do_frame({8'h11}, 8);
    total++; if (bus.spi_cmd_r !== 8'h11 || bus.spi_cmd_valid_r !== 1'b1)
      begin bad++; $display("FAIL co_cmd got=%h/%b exp=11/1",
                            bus.spi_cmd_r, bus.spi_cmd_valid_r); end
    total++; if ({bus.spi_addr_valid_r, bus.spi_data_valid_r} !== 2'b00)
      begin bad++; $display("FAIL co_valids got=%b%b exp=00",
                            bus.spi_addr_valid_r, bus.spi_data_valid_r); end
    total++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin bad++;
      $display("FAIL co_pulses got=%0d/%0d exp=1/0",
               n_done - d0, n_err - e0); end
  endtask

  task automatic test_short_frames;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    do_frame({8'h5A, 4'h9}, 12);
    total++; if (n_done - d0 !== 1 || n_err - e0 !== 1) begin bad++;
      $display("FAIL f12_pulses got=%0d/%0d exp=1/1",
               n_done - d0, n_err - e0); end
    d0 = n_done; e0 = n_err;
    do_frame({5'h13}, 5);
    total++; if (n_done - d0 !== 0 || n_err - e0 !== 1) begin bad++;
      $display("FAIL f5_pulses got=%0d/%0d exp=0/1",
               n_done - d0, n_err - e0); end
    total++; if (bus.spi_cmd_valid_r !== 1'b0) begin bad++;
      $display("FAIL f5_cmd_v got=%b exp=0", bus.spi_cmd_valid_r); end
  endtask

  task automatic test_overrun;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    do_frame({8'h3C, 8'h21, 48'hAAAAAAAAAAAA, 16'hFFFF}, 80);
    total++; if (bus.spi_data_r !== 48'hAAAAAAAAAAAA) begin bad++;
      $display("FAIL ov_data got=%h exp=aaaaaaaaaaaa", bus.spi_data_r); end
    total++; if (bus.spi_data_valid_r !== 1'b1) begin bad++;
      $display("FAIL ov_data_v got=%b exp=1", bus.spi_data_valid_r); end
    total++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin bad++;
      $display("FAIL ov_pulses got=%0d/%0d exp=1/0",
               n_done - d0, n_err - e0); end
  endtask

  task automatic test_reset_midframe;
    int d0, e0;
    host_cs_n = 1'b0;
    #50;
    send_bits({8'h77, 8'h12, 4'h5}, 20);
    resetn = 1'b0;
    #30;
    total++; if (bus.spi_cmd_r !== 8'h00 || bus.spi_cmd_valid_r !== 1'b0)
      begin bad++; $display("FAIL mr_rst got=%h/%b exp=00/0",
                            bus.spi_cmd_r, bus.spi_cmd_valid_r); end
    total++; if (bus.spi_data_r !== 48'h0 || bus.spi_addr_r !== 8'h00)
      begin bad++; $display("FAIL mr_rst_fields got=%h/%h exp=0/0",
                            bus.spi_data_r, bus.spi_addr_r); end
    resetn = 1'b1;
    #20;
    d0 = n_done; e0 = n_err;
    send_bits({8'h99, 8'h88, 4'h7}, 20);
    #50;
    total++; if (bus.spi_cmd_valid_r !== 1'b0 || bus.spi_cmd_r !== 8'h00)
      begin bad++; $display("FAIL mr_nocap got=%h/%b exp=00/0",
                            bus.spi_cmd_r, bus.spi_cmd_valid_r); end
    host_cs_n = 1'b1;
    #100;
    total++; if (n_done - d0 !== 0 || n_err - e0 !== 0) begin bad++;
      $display("FAIL mr_pulses got=%0d/%0d exp=0/0",
               n_done - d0, n_err - e0); end
    do_frame({8'hC3, 8'h5E, 48'h0123456789AB}, 64);
    total++; if (bus.spi_cmd_r !== 8'hC3 || bus.spi_addr_r !== 8'h5E)
      begin bad++; $display("FAIL mr_next got=%h/%h exp=c3/5e",
                            bus.spi_cmd_r, bus.spi_addr_r); end
    total++; if (bus.spi_data_r !== 48'h0123456789AB) begin bad++;
      $display("FAIL mr_next_data got=%h exp=0123456789ab",
               bus.spi_data_r); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = n_done;
    host_cs_n = 1'b0;
    #50;
    send_bits({8'h22, 8'h44, 48'h111111111111}, 64);
    #50;
    host_cs_n = 1'b1;
    #40;
    host_cs_n = 1'b0;
    #60;
    total++; if ({bus.spi_cmd_valid_r, bus.spi_addr_valid_r,
                  bus.spi_data_valid_r} !== 3'b000) begin bad++;
      $display("FAIL b2b_clr got=%b%b%b exp=000", bus.spi_cmd_valid_r,
               bus.spi_addr_valid_r, bus.spi_data_valid_r); end
    total++; if (bus.spi_cmd_r !== 8'h22) begin bad++;
      $display("FAIL b2b_hold got=%h exp=22", bus.spi_cmd_r); end
    send_bits({8'h33, 8'h55, 48'h0F0F0F0F0F0F}, 64);
    #50;
    host_cs_n = 1'b1;
    #100;
    total++; if (bus.spi_cmd_r !== 8'h33 || bus.spi_addr_r !== 8'h55)
      begin bad++; $display("FAIL b2b_hdr got=%h/%h exp=33/55",
                            bus.spi_cmd_r, bus.spi_addr_r); end
    total++; if (bus.spi_data_r !== 48'h0F0F0F0F0F0F) begin bad++;
      $display("FAIL b2b_data got=%h exp=0f0f0f0f0f0f", bus.spi_data_r); end
    total++; if (n_done - d0 !== 2) begin bad++;
      $display("FAIL b2b_done got=%0d exp=2", n_done - d0); end
  endtask

  initial begin
    resetn    = 1'b0;
    host_cs_n = 1'b1;
    host_sck  = 1'b0;
    host_mosi = 1'b0;
    rd_data   = '0;
    miso_cap  = '0;
    #23;
    test_reset();
    test_full_frame();
    test_readback();
    test_cmd_only();
    test_short_frames();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
